touch_point_sequencer: RTL and testbench
========================================

Name: touch_point_sequencer

Overview:
Controller that sequences the LT24 touchscreen driver for the digit-capture canvas.
- Wakes on pen-down and gates the driver's sample-enable strobe.
- Averages 2^LOG2_AVG raw 12-bit (x,y) samples, then clamps and scales the average to LCD pixel coordinates.
- Hands points to the canvas writer over a valid/ready interface.
- Detects pen-up by sample timeout and flags end of stroke.

Parameters:
- LOG2_AVG, 2, log2 of the number of raw samples averaged per point (1..4)
- X_MIN, 200, raw x value mapped to pixel 0
- X_MAX, 3900, raw x value mapped to pixel H_RES
- Y_MIN, 200, raw y value mapped to pixel 0
- Y_MAX, 3900, raw y value mapped to pixel V_RES
- H_RES, 240, horizontal pixel count
- V_RES, 320, vertical pixel count
- TIMEOUT_TICKS, 8, sample_tick strobes with no pos_ready (while sampling) that end a stroke
- MIN_DIST, 2, Manhattan distance threshold; used only with TOUCH_JITTER_FILTER_EN

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle sampling strobe from the rate divider
- adc_penirq_n  in  1  raw AD7843 pen interrupt, active low, asynchronous
- pos_ready  in  1  driver strobe: x_pos/y_pos are valid this cycle
- x_pos  in  12  raw x sample
- y_pos  in  12  raw y sample
- drv_en  out  1  enable strobe to the touchscreen driver
- point_valid  out  1  scaled point available
- point_ready  in  1  consumer accepts the point
- point_x  out  9  pixel x, 0..H_RES-1
- point_y  out  9  pixel y, 0..V_RES-1
- pen_down  out  1  high while a stroke is active
- stroke_end  out  1  one-cycle pulse at pen-up

Behaviour:
- Async reset: state IDLE. drv_en, point_valid, point_x, point_y, pen_down, stroke_end all 0. Accumulators, counters and synchroniser cleared. Reset mid-operation discards any partial average.
- adc_penirq_n passes through a 2-FF synchroniser to give pen_n_s. The synchroniser resets to 1.
- drv_en = sample_tick AND (state == SAMPLE). It is combinational from registered state.
- IDLE: when pen_n_s = 0, go to SAMPLE, set pen_down = 1, and clear acc_x, acc_y, sample count and timeout count.
- SAMPLE:
  - On pos_ready, add x_pos/y_pos into 16-bit accumulators, increment the count, and clear the timeout count.
  - Each sample_tick without pos_ready in the same cycle increments the timeout count.
  - When the count reaches 2^LOG2_AVG, go to SCALE.
  - When the timeout count reaches TIMEOUT_TICKS: pulse stroke_end for 1 cycle, set pen_down = 0, discard the partial average, go to IDLE.
  - If pos_ready and the timeout condition occur in the same cycle, the sample wins and the timeout count clears.
- SCALE, one cycle:
  - avg = acc >> LOG2_AVG.
  - Clamp avg to [MIN, MAX].
  - pix = ((avg - MIN) * SCALE) >> 12, where SCALE = ceil(RES*4096/(MAX-MIN)) is a localparam: 266 for x, 355 for y at defaults.
  - The product is 25 bits wide. Saturate pix to RES-1.
  - Register pix into point_x/point_y, then go to OUTPUT.
- Latency: point_valid rises 2 cycles after the final pos_ready.
- OUTPUT:
  - point_valid = 1. point_x/point_y are held stable until point_valid && point_ready.
  - drv_en = 0 and the timeout count is frozen, so no sample is lost or overwritten.
  - On handshake: clear the accumulators, go to SAMPLE, and drop point_valid the next cycle.
  - point_ready while point_valid = 0 is ignored.
- pos_ready outside SAMPLE is ignored.
- Pen-up is signalled only by timeout. adc_penirq_n is not sampled while pen_down = 1, because the AD7843 deasserts PENIRQ during conversions.

Optional Feature:
- Macro: TOUCH_JITTER_FILTER_EN.
- Defined: the block keeps the last emitted point for the current stroke. In SCALE, if a point has already been emitted this stroke and |dx|+|dy| < MIN_DIST, it skips OUTPUT, returns to SAMPLE and clears the accumulators. The first point of every stroke is always emitted. Reset and IDLE clear the "emitted" flag.
- Undefined: every average is emitted and MIN_DIST is unused.

Decomposition:
- Package touch_pkg holds:
  - state enum {IDLE, SAMPLE, SCALE, OUTPUT}
  - RAW_W = 12 and PIX_W = 9
  - default calibration constants
  - the SCALE derivation function
- One sub-module, touch_axis_scale: clamp, subtract, multiply, shift, saturate. It is purely combinational and instantiated once per axis with MIN/MAX/RES parameters.

Test Plan:
- Reset asserted mid-SAMPLE after 2 samples -> all outputs 0 immediately. After release with the pen held, the next point uses 4 fresh samples only.
- Pen down, 4 samples x=2050, y=2050 -> drv_en pulses only on ticks. point_valid 2 cycles after the 4th pos_ready. point_x=120, point_y=160.
- Samples x=100, y=4095 (all 4) -> point_x=0 (clamped), point_y=319 (saturated).
- Hold point_ready=0 for 20 cycles with ticks running -> point stable, drv_en=0, no stroke_end. point_ready=1 -> handshake, return to SAMPLE.
- After one point, stop pos_ready for 8 ticks -> single-cycle stroke_end, pen_down=0, IDLE. A 3-sample partial set is discarded, not emitted.
- With TOUCH_JITTER_FILTER_EN: second average differs by dx=1, dy=0 -> no point_valid. Third differs by dx=2 -> emitted.

Source files
------------

// File: rtl/touch_point_sequencer_pkg.sv
// Shared types and calibration constants for the LT24 touch point sequencer.
package touch_pkg;

  localparam int unsigned RAW_W  = 12;
  localparam int unsigned PIX_W  = 9;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned PROD_W = 25;

  localparam int unsigned X_MIN_DEF = 200;
  localparam int unsigned X_MAX_DEF = 3900;
  localparam int unsigned Y_MIN_DEF = 200;
  localparam int unsigned Y_MAX_DEF = 3900;
  localparam int unsigned H_RES_DEF = 240;
  localparam int unsigned V_RES_DEF = 320;

  typedef enum logic [1:0] {IDLE, SAMPLE, SCALE, OUTPUT} state_t;

  // Fixed-point gain (Q12) rounded up so the raw MAX lands on or past RES.
  function automatic int unsigned scale_factor(input int unsigned res,
                                               input int unsigned lo,
                                               input int unsigned hi);
    return (res * 4096 + (hi - lo) - 1) / (hi - lo);
  endfunction

endpackage

// File: rtl/touch_point_sequencer_axis_scale.sv
// Combinational raw-to-pixel mapping for one axis: clamp, offset, Q12 gain, saturate.
module touch_axis_scale
  import touch_pkg::*;
#(
  parameter int unsigned MIN = X_MIN_DEF,
  parameter int unsigned MAX = X_MAX_DEF,
  parameter int unsigned RES = H_RES_DEF
) (
  input  logic [RAW_W-1:0] avg,
  output logic [PIX_W-1:0] pix
);

  localparam int unsigned SCALE_K = scale_factor(RES, MIN, MAX);

  logic [RAW_W-1:0]  clamped;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] shifted;

  always_comb begin
    clamped = avg;
    if (avg < RAW_W'(MIN))
      clamped = RAW_W'(MIN);
    else if (avg > RAW_W'(MAX))
      clamped = RAW_W'(MAX);
    prod    = PROD_W'(clamped - RAW_W'(MIN)) * PROD_W'(SCALE_K);
    shifted = prod >> 12;
    pix     = (shifted > PROD_W'(RES - 1)) ? PIX_W'(RES - 1) : shifted[PIX_W-1:0];
  end

endmodule

// File: rtl/touch_point_sequencer.sv
// Pen-down driven sampling, averaging and pixel scaling for the LT24 touch canvas.
// Optional TOUCH_JITTER_FILTER_EN suppresses points closer than MIN_DIST to the last one.
module touch_point_sequencer
  import touch_pkg::*;
#(
  parameter int unsigned LOG2_AVG      = 2,
  parameter int unsigned X_MIN         = X_MIN_DEF,
  parameter int unsigned X_MAX         = X_MAX_DEF,
  parameter int unsigned Y_MIN         = Y_MIN_DEF,
  parameter int unsigned Y_MAX         = Y_MAX_DEF,
  parameter int unsigned H_RES         = H_RES_DEF,
  parameter int unsigned V_RES         = V_RES_DEF,
  parameter int unsigned TIMEOUT_TICKS = 8,
  parameter int unsigned MIN_DIST      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             adc_penirq_n,
  input  logic             pos_ready,
  input  logic [RAW_W-1:0] x_pos,
  input  logic [RAW_W-1:0] y_pos,
  output logic             drv_en,
  output logic             point_valid,
  input  logic             point_ready,
  output logic [PIX_W-1:0] point_x,
  output logic [PIX_W-1:0] point_y,
  output logic             pen_down,
  output logic             stroke_end
);

  localparam int unsigned CNT_W  = LOG2_AVG + 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned DIST_W = PIX_W + 1;
  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [TO_W-1:0]  LAST_TICK = TO_W'(TIMEOUT_TICKS - 1);

  if (LOG2_AVG < 1 || LOG2_AVG > 4 || X_MAX <= X_MIN || Y_MAX <= Y_MIN ||
      X_MAX > 4095 || Y_MAX > 4095 || H_RES > 512 || V_RES > 512 ||
      TIMEOUT_TICKS == 0 || MIN_DIST >= 1024) begin : g_bad_cfg
    $error("touch_point_sequencer: unsupported parameter set");
  end

  state_t            state;
  logic              pen_s1, pen_n_s;
  logic [ACC_W-1:0]  acc_x, acc_y;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   tcnt;
  logic [RAW_W-1:0]  avg_x, avg_y;
  logic [PIX_W-1:0]  pix_x, pix_y;
  logic              skip;

  assign avg_x  = acc_x[LOG2_AVG +: RAW_W];
  assign avg_y  = acc_y[LOG2_AVG +: RAW_W];
  assign drv_en = sample_tick && (state == SAMPLE);

  touch_axis_scale #(.MIN(X_MIN), .MAX(X_MAX), .RES(H_RES)) u_scale_x (
    .avg (avg_x),
    .pix (pix_x)
  );

  touch_axis_scale #(.MIN(Y_MIN), .MAX(Y_MAX), .RES(V_RES)) u_scale_y (
    .avg (avg_y),
    .pix (pix_y)
  );

`ifdef TOUCH_JITTER_FILTER_EN
  // point_x/point_y double as the last emitted point of this stroke.
  logic              emitted;
  logic [PIX_W-1:0]  dx, dy;
  logic [DIST_W-1:0] dist;

  always_comb begin
    dx   = (pix_x >= point_x) ? pix_x - point_x : point_x - pix_x;
    dy   = (pix_y >= point_y) ? pix_y - point_y : point_y - pix_y;
    dist = {1'b0, dx} + {1'b0, dy};
    skip = emitted && (dist < DIST_W'(MIN_DIST));
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pen_s1      <= 1'b1;
      pen_n_s     <= 1'b1;
      acc_x       <= '0;
      acc_y       <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      point_valid <= 1'b0;
      point_x     <= '0;
      point_y     <= '0;
      pen_down    <= 1'b0;
      stroke_end  <= 1'b0;
`ifdef TOUCH_JITTER_FILTER_EN
      emitted     <= 1'b0;
`endif
    end else begin
      pen_s1     <= adc_penirq_n;
      pen_n_s    <= pen_s1;
      stroke_end <= 1'b0;
      case (state)
        IDLE: begin
`ifdef TOUCH_JITTER_FILTER_EN
          emitted <= 1'b0;
`endif
          if (!pen_n_s) begin
            state    <= SAMPLE;
            pen_down <= 1'b1;
            acc_x    <= '0;
            acc_y    <= '0;
            cnt      <= '0;
            tcnt     <= '0;
          end
        end
        SAMPLE: begin
          // A sample arriving on the expiring tick keeps the stroke alive.
          if (pos_ready) begin
            acc_x <= acc_x + ACC_W'(x_pos);
            acc_y <= acc_y + ACC_W'(y_pos);
            cnt   <= cnt + 1'b1;
            tcnt  <= '0;
            if (cnt == LAST_SAMP)
              state <= SCALE;
          end else if (sample_tick) begin
            if (tcnt == LAST_TICK) begin
              state      <= IDLE;
              stroke_end <= 1'b1;
              pen_down   <= 1'b0;
              acc_x      <= '0;
              acc_y      <= '0;
              cnt        <= '0;
              tcnt       <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        SCALE: begin
          if (skip) begin
            state <= SAMPLE;
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
          end else begin
            state       <= OUTPUT;
            point_x     <= pix_x;
            point_y     <= pix_y;
            point_valid <= 1'b1;
`ifdef TOUCH_JITTER_FILTER_EN
            emitted     <= 1'b1;
`endif
          end
        end
        OUTPUT: begin
          if (point_ready) begin
            state       <= SAMPLE;
            point_valid <= 1'b0;
            acc_x       <= '0;
            acc_y       <= '0;
            cnt         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_point_sequencer.sv
// Directed plus randomized checks of touch_point_sequencer against an arithmetic reference model.
module tb_touch_point_sequencer;

  localparam int unsigned LOG2_AVG = 2;
  localparam int unsigned NS       = 1 << LOG2_AVG;
  localparam int unsigned X_MIN    = 200;
  localparam int unsigned X_MAX    = 3900;
  localparam int unsigned Y_MIN    = 200;
  localparam int unsigned Y_MAX    = 3900;
  localparam int unsigned H_RES    = 240;
  localparam int unsigned V_RES    = 320;
  localparam int unsigned TO_TICKS = 8;
  localparam int unsigned MIN_DIST = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        adc_penirq_n = 1'b1;
  logic        pos_ready = 1'b0;
  logic [11:0] x_pos = '0;
  logic [11:0] y_pos = '0;
  logic        drv_en;
  logic        point_valid;
  logic        point_ready = 1'b0;
  logic [8:0]  point_x;
  logic [8:0]  point_y;
  logic        pen_down;
  logic        stroke_end;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned sx[NS];
  int unsigned sy[NS];
  int unsigned last_x = 0, last_y = 0;
  bit          have_last = 0;

  touch_point_sequencer #(
    .LOG2_AVG(LOG2_AVG), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .H_RES(H_RES), .V_RES(V_RES), .TIMEOUT_TICKS(TO_TICKS), .MIN_DIST(MIN_DIST)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .adc_penirq_n(adc_penirq_n),
    .pos_ready(pos_ready), .x_pos(x_pos), .y_pos(y_pos), .drv_en(drv_en),
    .point_valid(point_valid), .point_ready(point_ready), .point_x(point_x),
    .point_y(point_y), .pen_down(pen_down), .stroke_end(stroke_end)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference mapping: mean of the samples, clamp, Q12 gain rounded up, saturate.
  function automatic int unsigned ref_pix(input int unsigned sum, input int unsigned lo,
                                          input int unsigned hi, input int unsigned res);
    int unsigned avg, k, p;
    avg = sum / NS;
    if (avg < lo) avg = lo;
    if (avg > hi) avg = hi;
    k = (res * 4096 + (hi - lo) - 1) / (hi - lo);
    p = ((avg - lo) * k) / 4096;
    return (p > res - 1) ? res - 1 : p;
  endfunction

  function automatic int unsigned absdiff(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic send_sample(input int unsigned x, input int unsigned y);
    sample_tick = 1'b1;
    #1 chk("drv_en_on_tick", drv_en, 1);
    step();
    sample_tick = 1'b0;
    pos_ready   = 1'b1;
    x_pos       = 12'(x);
    y_pos       = 12'(y);
    #1 chk("drv_en_no_tick", drv_en, 0);
    step();
    pos_ready = 1'b0;
  endtask

  task automatic handshake(input string tag);
    point_ready = 1'b1;
    step();
    point_ready = 1'b0;
    chk({tag, "_valid_drop"}, point_valid, 0);
  endtask

  task automatic send_point(input string tag, input bit do_hs);
    int unsigned xsum = 0, ysum = 0, ex, ey;
    bit emit;
    for (int i = 0; i < NS; i++) begin
      xsum += sx[i];
      ysum += sy[i];
    end
    ex = ref_pix(xsum, X_MIN, X_MAX, H_RES);
    ey = ref_pix(ysum, Y_MIN, Y_MAX, V_RES);
    emit = 1'b1;
`ifdef TOUCH_JITTER_FILTER_EN
    if (have_last && (absdiff(ex, last_x) + absdiff(ey, last_y) < MIN_DIST)) emit = 1'b0;
`endif
    for (int i = 0; i < NS; i++) send_sample(sx[i], sy[i]);
    chk({tag, "_scale_gap"}, point_valid, 0);
    step();
    chk({tag, "_valid"}, point_valid, 32'(emit));
    chk({tag, "_pen_down"}, pen_down, 1);
    if (emit) begin
      chk({tag, "_x"}, point_x, ex);
      chk({tag, "_y"}, point_y, ey);
      last_x = ex;
      last_y = ey;
      have_last = 1'b1;
      if (do_hs) handshake(tag);
    end
  endtask

  task automatic fill(input int unsigned x, input int unsigned y);
    for (int i = 0; i < NS; i++) begin
      sx[i] = x;
      sy[i] = y;
    end
  endtask

  task automatic wait_pen_down(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (pen_down) break;
      step();
    end
    chk(tag, pen_down, 1);
  endtask

  initial begin
    step();
    step();
    sample_tick = 1'b1;
    #1;
    chk("rst_drv_en", drv_en, 0);
    chk("rst_valid", point_valid, 0);
    chk("rst_x", point_x, 0);
    chk("rst_y", point_y, 0);
    chk("rst_pen_down", pen_down, 0);
    chk("rst_stroke_end", stroke_end, 0);
    reset = 1'b0;
    step();
    chk("idle_drv_en", drv_en, 0);
    sample_tick = 1'b0;
    pos_ready = 1'b1;
    x_pos = 12'd4000;
    y_pos = 12'd4000;
    step();
    pos_ready = 1'b0;
    step();
    chk("idle_pen_down", pen_down, 0);

    adc_penirq_n = 1'b0;
    wait_pen_down("wake_a");
    fill(2050, 2050);
    send_point("mid", 1'b0);

    // Consumer stalls while ticks and stray pos_ready keep arriving.
    for (int i = 0; i < 20; i++) begin
      sample_tick = (i % 2 == 0);
      pos_ready   = (i == 5);
      x_pos       = 12'd3800;
      #1;
      chk("hold_drv_en", drv_en, 0);
      chk("hold_valid", point_valid, 1);
      chk("hold_x", point_x, 120);
      chk("hold_stroke_end", stroke_end, 0);
      step();
    end
    sample_tick = 1'b0;
    pos_ready   = 1'b0;
    handshake("hold");

    fill(100, 4095);
    send_point("clamp", 1'b1);

    send_sample(3000, 3000);
    send_sample(3000, 3000);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", point_valid, 0);
    chk("mid_rst_x", point_x, 0);
    chk("mid_rst_y", point_y, 0);
    chk("mid_rst_pen_down", pen_down, 0);
    chk("mid_rst_stroke_end", stroke_end, 0);
    step();
    reset = 1'b0;
    have_last = 1'b0;
    wait_pen_down("wake_b");
    fill(1000, 3000);
    send_point("fresh", 1'b1);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < NS; i++) begin
        sx[i] = $urandom_range(0, 4095);
        sy[i] = $urandom_range(0, 4095);
      end
      send_point("rand", 1'b1);
    end

    send_sample(1500, 1500);
    send_sample(1500, 1500);
    send_sample(1500, 1500);
    adc_penirq_n = 1'b1;
    for (int t = 1; t <= TO_TICKS; t++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("to_stroke_end", stroke_end, (t == TO_TICKS) ? 1 : 0);
      chk("to_pen_down", pen_down, (t == TO_TICKS) ? 0 : 1);
      chk("to_valid", point_valid, 0);
      step();
      chk("to_stroke_end_gap", stroke_end, 0);
    end
    have_last = 1'b0;
    step();
    step();
    sample_tick = 1'b1;
    #1;
    chk("post_to_drv_en", drv_en, 0);
    chk("post_to_pen_down", pen_down, 0);
    chk("post_to_valid", point_valid, 0);
    sample_tick = 1'b0;

`ifdef TOUCH_JITTER_FILTER_EN
    adc_penirq_n = 1'b0;
    wait_pen_down("wake_j");
    fill(2050, 2050);
    send_point("jit_first", 1'b1);
    fill(2064, 2050);
    send_point("jit_dx1", 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("jit_dx1_quiet", point_valid, 0);
    end
    fill(2079, 2050);
    send_point("jit_dx2", 1'b1);
    chk("jit_dx2_x", last_x, 122);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
